// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the ALU and its UART front end.
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'd32;
   localparam logic [5:0] OP_SUB = 6'd34;
   localparam logic [5:0] OP_AND = 6'd36;
   localparam logic [5:0] OP_OR  = 6'd37;
   localparam logic [5:0] OP_XOR = 6'd38;
   localparam logic [5:0] OP_NOR = 6'd39;
   localparam logic [5:0] OP_SRA = 6'd3;
   localparam logic [5:0] OP_SRL = 6'd4;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

endpackage

// File: rtl/alu_op_check.sv
// Combinational opcode validator: an op byte is legal only if its upper bits are zero
// and its low NB_OP bits name one of the ALU's operations.
module alu_op_check
   import alu_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic [NB_DATA-1:0] i_op_byte,
   output logic               o_valid,
   output logic [NB_OP-1:0]   o_opcode
);

   logic upper_zero;
   logic known_op;

   assign o_opcode   = i_op_byte[NB_OP-1:0];
   assign upper_zero = ((i_op_byte >> NB_OP) == '0);

   always_comb begin
      known_op = 1'b0;
      case (o_opcode)
         NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
         NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL): known_op = 1'b1;
         default: known_op = 1'b0;
      endcase
   end

   assign o_valid = upper_zero & known_op;

endmodule

// File: rtl/alu_uart_if.sv
// UART byte-stream front end for the ALU: collects A, B, opcode, then ships the result.
// Optional partial-frame timeout is enabled with `define ALU_UART_IF_TIMEOUT_EN.
//
// state   | meaning
// WAIT_A  | idle, next received byte is operand A
// WAIT_B  | next received byte is operand B
// WAIT_OP | next received byte is the opcode, checked before acceptance
// EXEC    | ALU settles on registered inputs; result captured on exit
// WAIT_TX | transmitter busy with the result byte, waiting for i_tx_done
module alu_uart_if
   import alu_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_dato_a,
   output logic [NB_DATA-1:0] o_dato_b,
   output logic [NB_OP-1:0]   o_operation,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_err,
   output logic               o_overrun
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("alu_uart_if: TIMEOUT_CYCLES must be at least 2");
   end

   state_t             state_q, state_d;
   logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic               tx_start_q, tx_start_d;
   logic               err_q, err_d;
   logic               ovr_q, ovr_d;
   logic               op_valid;
   logic [NB_OP-1:0]   op_code;
   logic               timeout;

   alu_op_check #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) u_op_check (
      .i_op_byte (i_rx_data),
      .o_valid   (op_valid),
      .o_opcode  (op_code)
   );

`ifdef ALU_UART_IF_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_frame;

   assign in_frame = (state_q == WAIT_B) || (state_q == WAIT_OP);
   // A byte arriving on the terminal cycle wins over the timeout.
   assign timeout  = in_frame && !i_rx_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_d    = (i_rx_valid || !in_frame || timeout) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
      ovr_d      = 1'b0;
      case (state_q)
         WAIT_A: if (i_rx_valid) begin
            a_d     = i_rx_data;
            state_d = WAIT_B;
         end
         WAIT_B: if (i_rx_valid) begin
            b_d     = i_rx_data;
            state_d = WAIT_OP;
         end else if (timeout) begin
            err_d   = 1'b1;
            state_d = WAIT_A;
         end
         WAIT_OP: if (i_rx_valid) begin
            if (op_valid) begin
               op_d    = op_code;
               state_d = EXEC;
            end else begin
               err_d   = 1'b1;
               state_d = WAIT_A;
            end
         end else if (timeout) begin
            err_d   = 1'b1;
            state_d = WAIT_A;
         end
         EXEC: begin
            tx_data_d  = i_result;
            tx_start_d = 1'b1;
            ovr_d      = i_rx_valid;
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            ovr_d = i_rx_valid;
            if (i_tx_done) state_d = WAIT_A;
         end
         default: state_d = WAIT_A;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= WAIT_A;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
      end
   end

   assign o_dato_a    = a_q;
   assign o_dato_b    = b_q;
   assign o_operation = op_q;
   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_err       = err_q;
   assign o_overrun   = ovr_q;
   assign o_busy      = (state_q == EXEC) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if with a tie-in ALU; directed frames followed by random frames
// checked against a byte-level reference model.
module tb_alu_uart_if;
   import alu_pkg::*;

   logic       i_clk;
   logic       i_rst_n;
   logic [7:0] i_rx_data;
   logic       i_rx_valid;
   logic [7:0] i_result;
   logic       i_tx_done;
   logic [7:0] o_dato_a;
   logic [7:0] o_dato_b;
   logic [5:0] o_operation;
   logic [7:0] o_tx_data;
   logic       o_tx_start;
   logic       o_busy;
   logic       o_err;
   logic       o_overrun;

   int n_cmp = 0;
   int n_bad = 0;
   logic [5:0] m_op;

   alu_uart_if #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .i_result    (i_result),
      .i_tx_done   (i_tx_done),
      .o_dato_a    (o_dato_a),
      .o_dato_b    (o_dato_b),
      .o_operation (o_operation),
      .o_tx_data   (o_tx_data),
      .o_tx_start  (o_tx_start),
      .o_busy      (o_busy),
      .o_err       (o_err),
      .o_overrun   (o_overrun)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Stand-in for the team's combinational ALU.
   always_comb begin
      i_result = '0;
      case (o_operation)
         OP_ADD: i_result = o_dato_a + o_dato_b;
         OP_SUB: i_result = o_dato_a - o_dato_b;
         OP_AND: i_result = o_dato_a & o_dato_b;
         OP_OR:  i_result = o_dato_a | o_dato_b;
         OP_XOR: i_result = o_dato_a ^ o_dato_b;
         OP_NOR: i_result = ~(o_dato_a | o_dato_b);
         OP_SRA: i_result = $signed(o_dato_a) >>> o_dato_b;
         OP_SRL: i_result = o_dato_a >> o_dato_b;
         default: i_result = '0;
      endcase
   end

   function automatic bit ref_valid(input logic [7:0] op);
      int v;
      v = int'(op);
      return v inside {32, 34, 36, 37, 38, 39, 3, 4};
   endfunction

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] op);
      int ia, ib, sa, r;
      ia = int'(a);
      ib = int'(b);
      sa = (ia >= 128) ? ia - 256 : ia;
      r  = 0;
      if      (op == 8'd32) r = ia + ib;
      else if (op == 8'd34) r = ia - ib;
      else if (op == 8'd36) r = ia & ib;
      else if (op == 8'd37) r = ia | ib;
      else if (op == 8'd38) r = ia ^ ib;
      else if (op == 8'd39) r = ~(ia | ib);
      else if (op == 8'd3)  r = (ib >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ib);
      else if (op == 8'd4)  r = (ib >= 8) ? 0 : (ia >> ib);
      return r[7:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the byte is sampled on the next rising edge.
   task automatic send_byte(input logic [7:0] d);
      i_rx_data  = d;
      i_rx_valid = 1'b1;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input bit ovr);
      logic [7:0] exp;
      send_byte(a);
      check("dato_a", o_dato_a, a);
      send_byte(b);
      check("dato_b", o_dato_b, b);
      send_byte(op);
      if (ref_valid(op)) begin
         m_op = op[5:0];
         exp  = ref_alu(a, b, op);
         check("operation", o_operation, m_op);
         check("busy_exec", o_busy, 1);
         check("start_early", o_tx_start, 0);
         check("err_on_valid", o_err, 0);
         @(negedge i_clk);
         check("tx_start", o_tx_start, 1);
         check("tx_data", o_tx_data, exp);
         @(negedge i_clk);
         check("start_width", o_tx_start, 0);
         if (ovr) begin
            send_byte(8'h55);
            check("overrun", o_overrun, 1);
            check("ovr_dato_a", o_dato_a, a);
            check("ovr_busy", o_busy, 1);
            @(negedge i_clk);
            check("overrun_width", o_overrun, 0);
         end
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
         check("busy_wait_tx", o_busy, 1);
         i_tx_done = 1'b1;
         @(negedge i_clk);
         i_tx_done = 1'b0;
         check("idle_after_done", o_busy, 0);
         check("tx_data_hold", o_tx_data, exp);
      end else begin
         check("err", o_err, 1);
         check("op_hold", o_operation, m_op);
         check("busy_after_err", o_busy, 0);
         @(negedge i_clk);
         check("err_width", o_err, 0);
         check("no_start", o_tx_start, 0);
      end
   endtask

   initial begin
      logic [7:0] ra, rb, rop;
      logic [7:0] valid_ops [8];
      valid_ops = '{8'd32, 8'd34, 8'd36, 8'd37, 8'd38, 8'd39, 8'd3, 8'd4};
      i_rst_n    = 1'b0;
      i_rx_data  = '0;
      i_rx_valid = 1'b0;
      i_tx_done  = 1'b0;
      m_op       = '0;
      #2;
      check("rst_dato_a", o_dato_a, 0);
      check("rst_dato_b", o_dato_b, 0);
      check("rst_operation", o_operation, 0);
      check("rst_tx_data", o_tx_data, 0);
      check("rst_tx_start", o_tx_start, 0);
      check("rst_busy", o_busy, 0);
      check("rst_err", o_err, 0);
      check("rst_overrun", o_overrun, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      do_frame(8'h05, 8'h03, 8'h20, 1'b0);
      check("add_result", o_tx_data, 8'h08);
      do_frame(8'h03, 8'h05, 8'h22, 1'b0);
      do_frame(8'hF0, 8'h0F, 8'h27, 1'b0);
      do_frame(8'h01, 8'h02, 8'h21, 1'b0);
      do_frame(8'h01, 8'h02, 8'hE0, 1'b0);
      do_frame(8'h80, 8'h02, 8'h03, 1'b0);
      do_frame(8'h80, 8'h02, 8'h04, 1'b0);
      do_frame(8'h09, 8'h09, 8'h26, 1'b1);
      do_frame(8'h02, 8'h02, 8'h24, 1'b0);

      // tx_done while idle must not disturb the next frame
      i_tx_done = 1'b1;
      @(negedge i_clk);
      i_tx_done = 1'b0;
      check("tx_done_idle", o_busy, 0);

      send_byte(8'h11);
      send_byte(8'h22);
      #2 i_rst_n = 1'b0;
      #1;
      check("midrst_dato_a", o_dato_a, 0);
      check("midrst_dato_b", o_dato_b, 0);
      check("midrst_operation", o_operation, 0);
      check("midrst_tx_start", o_tx_start, 0);
      check("midrst_busy", o_busy, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      m_op    = '0;
      @(negedge i_clk);
      check("midrst_no_start", o_tx_start, 0);
      do_frame(8'h01, 8'h01, 8'h20, 1'b0);

`ifdef ALU_UART_IF_TIMEOUT_EN
      send_byte(8'h33);
      repeat (15) @(negedge i_clk);
      check("to_early", o_err, 0);
      @(negedge i_clk);
      check("to_err", o_err, 1);
      check("to_busy", o_busy, 0);
      @(negedge i_clk);
      check("to_err_width", o_err, 0);
      do_frame(8'h07, 8'h01, 8'h22, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : valid_ops[$urandom_range(0, 7)];
         do_frame(ra, rb, rop, $urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
